// File: rtl/udp_rx_filter_pkg.sv
// Purpose: shared Ethernet/IPv4/UDP header constants, FSM state types and the
//          header byte-match helper for the UDP receive filter. The header
//          offsets and field values are the same ones the downstream register
//          decoder uses.
// Ports:   none (package).
package udp_rx_filter_pkg;

   // Header byte offsets within the frame (FCS already stripped)
   localparam int unsigned OFF_DST_MAC  = 0;
   localparam int unsigned OFF_ETYPE    = 12;
   localparam int unsigned OFF_IP_VIHL  = 14;
   localparam int unsigned OFF_IP_PROTO = 23;
   localparam int unsigned OFF_DST_IP   = 30;
   localparam int unsigned OFF_DST_PORT = 36;
   localparam int unsigned OFF_UDP_LEN  = 38;
   localparam int unsigned OFF_PAYLOAD  = 42;

   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  IP_VIHL_V4  = 8'h45;
   localparam logic [7:0]  PROTO_UDP   = 8'h11;
   localparam logic [15:0] UDP_HDR_LEN = 16'd8;

   localparam int unsigned CNT_W = 12;

   typedef enum logic [2:0] {
      CAP_IDLE, CAP_HDR, CAP_PAYLOAD, CAP_TAIL, CAP_BAD
   } cap_state_e;

   typedef enum logic [1:0] {
      RPL_IDLE, RPL_READ, RPL_GAP
   } rpl_state_e;

   // True when byte idx either carries no checked field or matches its expected value
   function automatic logic hdr_byte_ok(input logic [CNT_W-1:0] idx,
                                        input logic [7:0]       b,
                                        input logic [47:0]      mac,
                                        input logic [31:0]      ip,
                                        input logic [15:0]      port);
      logic [7:0] exp_b;
      logic       chk;
      exp_b = 8'h00;
      chk   = 1'b1;
      case (idx)
         12'(OFF_DST_MAC + 0):  exp_b = mac[47:40];
         12'(OFF_DST_MAC + 1):  exp_b = mac[39:32];
         12'(OFF_DST_MAC + 2):  exp_b = mac[31:24];
         12'(OFF_DST_MAC + 3):  exp_b = mac[23:16];
         12'(OFF_DST_MAC + 4):  exp_b = mac[15:8];
         12'(OFF_DST_MAC + 5):  exp_b = mac[7:0];
         12'(OFF_ETYPE + 0):    exp_b = ETYPE_IPV4[15:8];
         12'(OFF_ETYPE + 1):    exp_b = ETYPE_IPV4[7:0];
         12'(OFF_IP_VIHL):      exp_b = IP_VIHL_V4;
         12'(OFF_IP_PROTO):     exp_b = PROTO_UDP;
         12'(OFF_DST_IP + 0):   exp_b = ip[31:24];
         12'(OFF_DST_IP + 1):   exp_b = ip[23:16];
         12'(OFF_DST_IP + 2):   exp_b = ip[15:8];
         12'(OFF_DST_IP + 3):   exp_b = ip[7:0];
         12'(OFF_DST_PORT + 0): exp_b = port[15:8];
         12'(OFF_DST_PORT + 1): exp_b = port[7:0];
         default:               chk   = 1'b0;
      endcase
      return !chk || (b == exp_b);
   endfunction

endpackage

// File: rtl/udp_rx_filter_if.sv
// Purpose: MAC-side byte stream plus validated payload stream and counters
//          of the UDP receive filter.
// Ports:   master drives the MAC byte stream and observes the payload side;
//          slave is the filter itself.
interface udp_rx_filter_if;
   logic [7:0]  in_d;
   logic        in_dv;
   logic        in_last;
   logic        in_fcs_ok;
   logic [7:0]  out_d;
   logic        out_dv;
   logic        out_last;
   logic [15:0] good_cnt;
   logic [15:0] drop_cnt;

   modport master (
      output in_d, in_dv, in_last, in_fcs_ok,
      input  out_d, out_dv, out_last, good_cnt, drop_cnt
   );

   modport slave (
      input  in_d, in_dv, in_last, in_fcs_ok,
      output out_d, out_dv, out_last, good_cnt, drop_cnt
   );
endinterface

// File: rtl/udp_rx_filter_ram.sv
// Purpose: simple dual-port payload RAM; address MSB selects the ping-pong bank.
// Ports:   clk; write port wr_en_i/wr_addr_i/wr_data_i; read port rd_en_i/rd_addr_i
//          with registered rd_data_o one cycle after the read is issued.
module udp_rx_filter_ram #(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
   end
endmodule

// File: rtl/udp_rx_filter.sv
// Purpose: parse Ethernet/IPv4/UDP headers, match our MAC/IP/port, hold the
//          payload in a ping-pong buffer until FCS is known and replay only
//          fully validated payloads as a contiguous byte stream.
// Ports:   clk, rst (async, active high); bus.slave carries in_d/in_dv/in_last/
//          in_fcs_ok from the MAC and out_d/out_dv/out_last, good_cnt, drop_cnt.
module udp_rx_filter
   import udp_rx_filter_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR = 48'h0102_0304_0506,
   parameter logic [31:0] IP_ADDR  = 32'h0A42_2A2A,
   parameter logic [15:0] UDP_PORT = 16'd11300,
   parameter int unsigned BUF_AW   = 11
) (
   input logic           clk,
   input logic           rst,
   udp_rx_filter_if.slave bus
);
   localparam int unsigned RAM_AW  = BUF_AW + 1;
   localparam logic [15:0] MAX_LEN = 16'(1 << BUF_AW);

   cap_state_e        cap_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        len_hi_q;
   logic [15:0]       len_q;
   logic              cap_bank_q;
   logic              commit_good_q, commit_drop_q;

   rpl_state_e        rpl_q;
   logic              rpl_bank_q;
   logic [15:0]       rpl_len_q;
   logic [BUF_AW-1:0] rd_addr_q;
   logic              rd_vld_q, rd_last_q;
   logic [7:0]        out_d_q;
   logic              out_dv_q, out_last_q;
   logic [15:0]       good_cnt_q, drop_cnt_q;

   logic [7:0]        rd_data;
   logic [15:0]       len_c;
   logic [CNT_W-1:0]  pidx_c;
   logic              hdr_ok_c, last_pl_c, wr_en_c, rd_en_c, rd_end_c;

   // Byte index within the current frame, saturating
   always_comb begin
      cnt_d = cnt_q;
      if (!bus.in_dv || bus.in_last) cnt_d = '0;
      else if (cnt_q != '1)          cnt_d = cnt_q + 12'd1;
   end

   assign hdr_ok_c  = hdr_byte_ok(cnt_q, bus.in_d, MAC_ADDR, IP_ADDR, UDP_PORT);
   assign len_c     = {len_hi_q, bus.in_d} - UDP_HDR_LEN;
   assign pidx_c    = cnt_q - 12'(OFF_PAYLOAD);
   assign last_pl_c = (16'(pidx_c) == len_q - 16'd1);
   assign wr_en_c   = (cap_q == CAP_PAYLOAD) && bus.in_dv;
   assign rd_en_c   = (rpl_q == RPL_READ);
   assign rd_end_c  = (16'(rd_addr_q) == rpl_len_q - 16'd1);

   // Capture FSM: header match, payload write, accept/drop verdict at frame end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q         <= CAP_IDLE;
         cnt_q         <= '0;
         len_hi_q      <= '0;
         len_q         <= '0;
         commit_good_q <= 1'b0;
         commit_drop_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         commit_good_q <= 1'b0;
         commit_drop_q <= 1'b0;
         if (cap_q == CAP_IDLE) begin
            if (bus.in_dv) begin
               if (bus.in_last)    commit_drop_q <= 1'b1;
               else if (!hdr_ok_c) cap_q         <= CAP_BAD;
               else                cap_q         <= CAP_HDR;
            end
         end else if (!bus.in_dv) begin
            commit_drop_q <= 1'b1;
            cap_q         <= CAP_IDLE;
         end else if (bus.in_last) begin
            // Last byte must land in padding: ending on or before the final payload byte is short
            if (cap_q == CAP_TAIL && bus.in_fcs_ok) commit_good_q <= 1'b1;
            else                                    commit_drop_q <= 1'b1;
            cap_q <= CAP_IDLE;
         end else begin
            case (cap_q)
               CAP_HDR: begin
                  if (cnt_q == 12'(OFF_UDP_LEN))     len_hi_q <= bus.in_d;
                  if (cnt_q == 12'(OFF_UDP_LEN + 1)) len_q    <= len_c;
                  if (!hdr_ok_c ||
                      (cnt_q == 12'(OFF_UDP_LEN + 1) && (len_c == 16'd0 || len_c > MAX_LEN)))
                     cap_q <= CAP_BAD;
                  else if (cnt_q == 12'(OFF_PAYLOAD - 1))
                     cap_q <= CAP_PAYLOAD;
               end
               CAP_PAYLOAD: if (last_pl_c) cap_q <= CAP_TAIL;
               default: ;
            endcase
         end
      end
   end

   // Commit and replay FSM: hand the filled bank to replay, stream it out, then force a gap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt_q <= '0;
         drop_cnt_q <= '0;
         cap_bank_q <= 1'b0;
         rpl_q      <= RPL_IDLE;
         rpl_bank_q <= 1'b0;
         rpl_len_q  <= '0;
         rd_addr_q  <= '0;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
         out_d_q    <= '0;
         out_dv_q   <= 1'b0;
         out_last_q <= 1'b0;
      end else begin
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         if (commit_good_q && rpl_q == RPL_IDLE) begin
            good_cnt_q <= good_cnt_q + 16'd1;
            cap_bank_q <= ~cap_bank_q;
            rpl_bank_q <= cap_bank_q;
            rpl_len_q  <= len_q;
            rd_addr_q  <= '0;
            rpl_q      <= RPL_READ;
         end else if (commit_good_q || commit_drop_q) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         case (rpl_q)
            RPL_READ: begin
               rd_vld_q  <= 1'b1;
               rd_last_q <= rd_end_c;
               rd_addr_q <= rd_addr_q + 1'b1;
               if (rd_end_c) rpl_q <= RPL_GAP;
            end
            RPL_GAP: rpl_q <= RPL_IDLE;
            default: ;
         endcase
         out_dv_q   <= rd_vld_q;
         out_last_q <= rd_last_q;
         out_d_q    <= rd_vld_q ? rd_data : 8'h00;
      end
   end

   udp_rx_filter_ram #(.AW(RAM_AW)) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en_c),
      .wr_addr_i ({cap_bank_q, pidx_c[BUF_AW-1:0]}),
      .wr_data_i (bus.in_d),
      .rd_en_i   (rd_en_c),
      .rd_addr_i ({rpl_bank_q, rd_addr_q}),
      .rd_data_o (rd_data)
   );

   assign bus.out_d    = out_d_q;
   assign bus.out_dv   = out_dv_q;
   assign bus.out_last = out_last_q;
   assign bus.good_cnt = good_cnt_q;
   assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_udp_rx_filter.sv
// Purpose: self-checking bench for udp_rx_filter: directed scenarios plus
//          randomized frames checked every cycle against a frame-level model.
// Ports:   none (top-level bench).
module tb_udp_rx_filter;
   localparam logic [47:0] MAC  = 48'h0102_0304_0506;
   localparam logic [31:0] IP   = 32'h0A42_2A2A;
   localparam logic [15:0] PORT = 16'd11300;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   udp_rx_filter_if bus ();
   udp_rx_filter dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level model state: expected output bytes keyed by cycle, counter events keyed by cycle
   logic [7:0] fr [$];
   logic [7:0] exp_byte [int];
   bit         exp_last [int];
   int         ev_kind  [int];
   int         busy_until = 0;
   int         m_good = 0, m_drop = 0;
   int         last_l_edge = 0;
   int         last_dv_start = 0, dv_run = 0;
   bit         prev_dv = 1'b0;
   int         hidx [16] = '{0, 1, 2, 3, 4, 5, 12, 13, 14, 23, 30, 31, 32, 33, 36, 37};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_byte(input int idx, input logic [7:0] val);
      if (idx < fr.size()) fr[idx] = val;
   endtask

   // Well-formed frame of nbytes with the given UDP length field and random payload
   task automatic make_frame(input logic [15:0] udp_len, input int nbytes);
      fr.delete();
      for (int i = 0; i < nbytes; i++) fr.push_back(8'($urandom));
      for (int i = 0; i < 6; i++) set_byte(i, 8'(MAC >> (40 - 8 * i)));
      set_byte(12, 8'h08); set_byte(13, 8'h00); set_byte(14, 8'h45); set_byte(23, 8'h11);
      for (int i = 0; i < 4; i++) set_byte(30 + i, 8'(IP >> (24 - 8 * i)));
      set_byte(36, PORT[15:8]); set_byte(37, PORT[7:0]);
      set_byte(38, udp_len[15:8]); set_byte(39, udp_len[7:0]);
   endtask

   function automatic bit frame_ok(input bit fcs);
      logic [15:0] ln;
      if (fr.size() < 42) return 1'b0;
      if ({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]} != MAC) return 1'b0;
      if ({fr[12], fr[13]} != 16'h0800 || fr[14] != 8'h45 || fr[23] != 8'h11) return 1'b0;
      if ({fr[30], fr[31], fr[32], fr[33]} != IP || {fr[36], fr[37]} != PORT) return 1'b0;
      ln = {fr[38], fr[39]} - 16'd8;
      if (ln == 16'd0 || ln > 16'd2048) return 1'b0;
      if (fr.size() <= 42 + int'(ln)) return 1'b0;
      return fcs;
   endfunction

   task automatic model_end(input int l_edge, input bit fcs, input bit cut);
      int c;
      int len;
      if (cut) begin
         ev_kind[l_edge + 2] = 2;
         return;
      end
      c = l_edge + 1;
      if (frame_ok(fcs) && c >= busy_until) begin
         len = int'({fr[38], fr[39]}) - 8;
         ev_kind[c] = 1;
         for (int i = 0; i < len; i++) exp_byte[c + 2 + i] = fr[42 + i];
         exp_last[c + 1 + len] = 1'b1;
         busy_until = c + len + 2;
      end else begin
         ev_kind[c] = 2;
      end
   endtask

   task automatic send_frame(input bit fcs, input int ifg, input bit cut);
      int n;
      n = fr.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.in_dv     = 1'b1;
         bus.in_d      = fr[i];
         bus.in_last   = !cut && (i == n - 1);
         bus.in_fcs_ok = bus.in_last ? fcs : 1'($urandom);
      end
      last_l_edge = cyc + 1;
      model_end(last_l_edge, fcs, cut);
      @(posedge clk); #1;
      bus.in_dv = 1'b0; bus.in_last = 1'b0; bus.in_d = 8'h00; bus.in_fcs_ok = 1'b0;
      repeat (ifg - 1) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      bit el;
      if (!rst) begin
         if (ev_kind.exists(cyc)) begin
            if (ev_kind[cyc] == 1) m_good++; else m_drop++;
            ev_kind.delete(cyc);
         end
         if (exp_byte.exists(cyc)) begin
            el = exp_last.exists(cyc);
            chk("out_dv", 32'(bus.out_dv), 32'd1);
            chk("out_d", 32'(bus.out_d), 32'(exp_byte[cyc]));
            chk("out_last", 32'(bus.out_last), 32'(el));
            exp_byte.delete(cyc);
            if (el) exp_last.delete(cyc);
         end else begin
            chk("out_dv_idle", 32'(bus.out_dv), 32'd0);
            chk("out_last_idle", 32'(bus.out_last), 32'd0);
            chk("out_d_idle", 32'(bus.out_d), 32'd0);
         end
         chk("good_cnt", 32'(bus.good_cnt), 32'(m_good & 16'hFFFF));
         chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop & 16'hFFFF));
         if (bus.out_dv && !prev_dv) begin
            last_dv_start = cyc;
            dv_run = 0;
         end
         if (bus.out_dv) dv_run++;
         prev_dv = bus.out_dv;
      end
   end

   initial begin
      bus.in_d = 8'h00; bus.in_dv = 1'b0; bus.in_last = 1'b0; bus.in_fcs_ok = 1'b0;
      idle(3); #1;
      chk("rst_out_dv", 32'(bus.out_dv), 32'd0);
      chk("rst_out_d", 32'(bus.out_d), 32'd0);
      chk("rst_good", 32'(bus.good_cnt), 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
      #1 rst = 1'b0;
      idle(3);

      // Good frame, 8-byte payload padded to 60 bytes
      make_frame(16'd16, 60);
      send_frame(1'b1, 20, 1'b0);
      idle(10);
      chk("t1_latency", 32'(last_dv_start - last_l_edge), 32'd3);
      chk("t1_len", 32'(dv_run), 32'd8);
      chk("t1_good", 32'(bus.good_cnt), 32'd1);
      chk("t1_drop", 32'(bus.drop_cnt), 32'd0);

      // Bad FCS
      send_frame(1'b0, 20, 1'b0);
      idle(10);
      chk("t2_good", 32'(bus.good_cnt), 32'd1);
      chk("t2_drop", 32'(bus.drop_cnt), 32'd1);

      // Header mismatches: port 11301, IP, ethertype 0x0806, proto TCP
      make_frame(16'd16, 60); set_byte(37, 8'h25); send_frame(1'b1, 10, 1'b0);
      make_frame(16'd16, 60); set_byte(33, 8'h2B); send_frame(1'b1, 10, 1'b0);
      make_frame(16'd16, 60); set_byte(13, 8'h06); send_frame(1'b1, 10, 1'b0);
      make_frame(16'd16, 60); set_byte(23, 8'h06); send_frame(1'b1, 10, 1'b0);
      idle(10);
      chk("t3_drop", 32'(bus.drop_cnt), 32'd5);

      // Padding with 1-byte payload; then a truncated frame
      make_frame(16'd9, 60);
      send_frame(1'b1, 20, 1'b0);
      idle(10);
      chk("t4_len", 32'(dv_run), 32'd1);
      chk("t4_good", 32'(bus.good_cnt), 32'd2);
      make_frame(16'd40, 50);
      send_frame(1'b1, 20, 1'b0);
      idle(10);
      chk("t4_drop", 32'(bus.drop_cnt), 32'd6);

      // Back-to-back 1400-byte payloads, then a frame committed while replay is busy
      make_frame(16'd1408, 1450); send_frame(1'b1, 20, 1'b0);
      make_frame(16'd1408, 1450); send_frame(1'b1, 20, 1'b0);
      make_frame(16'd16, 60);     send_frame(1'b1, 20, 1'b0);
      idle(1450);
      chk("t5_len", 32'(dv_run), 32'd1400);
      chk("t5_good", 32'(bus.good_cnt), 32'd4);
      chk("t5_drop", 32'(bus.drop_cnt), 32'd7);

      // Length boundaries: 0, negative, 2049 rejected; 2048 accepted
      make_frame(16'd8, 60);    send_frame(1'b1, 10, 1'b0);
      make_frame(16'd7, 60);    send_frame(1'b1, 10, 1'b0);
      make_frame(16'd2057, 60); send_frame(1'b1, 10, 1'b0);
      make_frame(16'd2056, 2092); send_frame(1'b1, 10, 1'b0);
      idle(2070);
      chk("t6_len", 32'(dv_run), 32'd2048);
      chk("t6_good", 32'(bus.good_cnt), 32'd5);
      chk("t6_drop", 32'(bus.drop_cnt), 32'd10);

      // in_dv falls without in_last
      make_frame(16'd16, 60);
      send_frame(1'b1, 10, 1'b1);
      idle(5);
      chk("t7_drop", 32'(bus.drop_cnt), 32'd11);

      // Reset mid-replay
      make_frame(16'd208, 250);
      send_frame(1'b1, 2, 1'b0);
      for (int i = 0; i < 100 && !bus.out_dv; i++) @(negedge clk);
      chk("t8_wait_dv", 32'(bus.out_dv), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      exp_byte.delete(); exp_last.delete(); ev_kind.delete();
      busy_until = 0; m_good = 0; m_drop = 0; prev_dv = 1'b0;
      #1;
      chk("t8_out_dv", 32'(bus.out_dv), 32'd0);
      chk("t8_out_last", 32'(bus.out_last), 32'd0);
      chk("t8_out_d", 32'(bus.out_d), 32'd0);
      chk("t8_good", 32'(bus.good_cnt), 32'd0);
      chk("t8_drop", 32'(bus.drop_cnt), 32'd0);
      idle(2); #2;
      rst = 1'b0;
      idle(2);
      make_frame(16'd16, 60);
      send_frame(1'b1, 20, 1'b0);
      idle(10);
      chk("t8_len", 32'(dv_run), 32'd8);
      chk("t8_good_after", 32'(bus.good_cnt), 32'd1);

      // Randomized frames with short gaps so commits also hit a busy replay
      for (int f = 0; f < 60; f++) begin
         int          len, pad, sel, k;
         logic [15:0] ul;
         len = $urandom_range(1, 64);
         pad = $urandom_range(0, 6);
         sel = $urandom_range(0, 9);
         ul  = 16'(len + 8);
         if (sel == 0) ul = 16'($urandom_range(0, 8));
         make_frame(ul, 42 + len + pad);
         if (sel == 1) begin
            k = hidx[$urandom_range(0, 15)];
            fr[k] = fr[k] ^ 8'($urandom_range(1, 255));
         end
         if (sel == 2) begin
            k = $urandom_range(1, 42 + len);
            while (fr.size() > k) void'(fr.pop_back());
         end
         send_frame($urandom_range(0, 7) != 0, $urandom_range(1, 40), sel == 3);
      end
      idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
